// File: rtl/vec_mag_arbiter.sv
// vec_mag_arbiter
//   Shares one vec_mag_core between NUM_REQ AXI-Stream requesters. A
//   round-robin arbiter grants one requester at a time and holds the grant
//   until that requester's tlast beat has been issued to the core. Every
//   issued beat pushes the granted index into a tag FIFO. Because the core
//   returns results in order, the FIFO head names the owner of the result
//   currently presented by the core, and that index goes out on m_axis_tdest.
//
// Handshake rule on every AXI-Stream port: a beat transfers on a rising clock
//   edge where tvalid && tready are both 1. tvalid never waits on tready.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_axis_*        NUM_REQ requester inputs, requester i data at [i*BW +: BW]
//   m_core_*        request beats towards the core
//   s_core_*        results coming back from the core
//   m_axis_*        tagged results out (tdest = owning requester)
//   busy_o          arbiter locked or results still owed by the core
//   inflight_o      tag FIFO occupancy
//   err_o           sticky: the core presented a result with no tag to own it
//   fsm_state       debug view of the arbiter FSM (0 = IDLE, 1 = LOCKED)
module vec_mag_arbiter #(
  parameter int COORD_WIDTH  = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8,
  localparam int BW = 4 * COORD_WIDTH,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_REQ*BW-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]    s_axis_tvalid,
  input  logic [NUM_REQ-1:0]    s_axis_tlast,
  output logic [NUM_REQ-1:0]    s_axis_tready,
  output logic [BW-1:0]         m_core_tdata,
  output logic                  m_core_tvalid,
  output logic                  m_core_tlast,
  input  logic                  m_core_tready,
  input  logic [BW-1:0]         s_core_tdata,
  input  logic                  s_core_tvalid,
  output logic                  s_core_tready,
  output logic [BW-1:0]         m_axis_tdata,
  output logic [IW-1:0]         m_axis_tdest,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic [CW-1:0]         inflight_o,
  output logic                  err_o,
  output logic                  fsm_state
);

  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] grant, grant_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [IW-1:0] pick;
  logic          any_valid;

  logic [IW-1:0] tag_mem [MAX_INFLIGHT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, issue, accept;

  logic [BW-1:0] sel_data;
  logic          sel_valid, sel_last;

  // Requester index base+off, wrapped into 0..NUM_REQ-1 (off < NUM_REQ).
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == MAX_INFLIGHT - 1) return '0;
    return p + PW'(1);
  endfunction

  // Round-robin pick: walk offsets from the far end so the requester closest
  // to rr_ptr (cyclically) is the one that sticks.
  always_comb begin
    pick      = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_axis_tvalid[rr_index(rr_ptr, k)]) begin
        pick      = rr_index(rr_ptr, k);
        any_valid = 1'b1;
      end
    end
  end

  // Granted requester's beat, steered onto the core port.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IW'(i)) begin
        sel_data  = s_axis_tdata[i*BW +: BW];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign full  = (count == CW'(MAX_INFLIGHT));
  assign empty = (count == '0);

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    rr_ptr_nx     = rr_ptr;
    s_axis_tready = '0;
    m_core_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_nx = pick;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        // A full tag FIFO stalls the request side; no beat may be issued
        // without a slot for its tag.
        m_core_tvalid = sel_valid && !full;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant == IW'(i)) s_axis_tready[i] = m_core_tready && !full;
        end
        if (sel_valid && !full && m_core_tready && sel_last) begin
          state_nx  = IDLE;
          rr_ptr_nx = rr_index(grant, 1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
    end
  end

  assign m_core_tdata = sel_data;
  assign m_core_tlast = sel_last;
  assign issue        = m_core_tvalid && m_core_tready;

  // Result path is purely combinational; a result with no tag is held off.
  assign m_axis_tvalid = s_core_tvalid && !empty;
  assign s_core_tready = m_axis_tready && !empty;
  assign m_axis_tdata  = s_core_tdata;
  assign m_axis_tdest  = tag_mem[rd_ptr];
  assign accept        = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk) begin
    if (issue) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue)  wr_ptr <= ptr_inc(wr_ptr);
      if (accept) rd_ptr <= ptr_inc(rd_ptr);
      if (issue && !accept)      count <= count + CW'(1);
      else if (!issue && accept) count <= count - CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                   err_o <= 1'b0;
    else if (s_core_tvalid && empty) err_o <= 1'b1;
  end

  assign inflight_o = count;
  assign busy_o     = (state != IDLE) || !empty;
  assign fsm_state  = (state == LOCKED);

endmodule
